// File: rtl/rca16_bus_pkg.sv
// Shared definitions for the rca16 host: FSM encoding, adder register map,
// latency constant and the write-byte selector.
package rca16_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RD     = 3'd3,
    ST_CAP    = 3'd4,
    ST_RSP    = 3'd5
  } state_t;

  // Write-side register map
  localparam logic [7:0] A_LO   = 8'd0;
  localparam logic [7:0] A_HI   = 8'd1;
  localparam logic [7:0] B_LO   = 8'd2;
  localparam logic [7:0] B_HI   = 8'd3;
  localparam logic [7:0] CIN    = 8'd4;
  // Read-side register map
  localparam logic [7:0] SUM_LO = 8'd0;
  localparam logic [7:0] SUM_HI = 8'd1;
  localparam logic [7:0] COUT   = 8'd2;

  // Accept edge to rsp_valid, excluding the settle gap
  localparam int BASE_LATENCY = 9;

  function automatic logic [7:0] wr_byte(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic        cin,
                                         input logic [2:0]  idx);
    logic [7:0] v;
    v = 8'd0;
    case (idx)
      3'd0:    v = a[7:0];
      3'd1:    v = a[15:8];
      3'd2:    v = b[7:0];
      3'd3:    v = b[15:8];
      3'd4:    v = {7'd0, cin};
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rca16_host.sv
// Request/response front end that drives a byte-wide register bus to a
// 16-bit ripple-carry adder wrapper: write operands, settle, read result.
module rca16_host
  import rca16_bus_pkg::*;
#(
  parameter logic [7:0] ADDR_IDLE     = 8'hFF,
  parameter int         SETTLE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_cin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_err,
  output logic [7:0]  BUS_DIN,
  output logic [7:0]  BUS_ADDR,
  output logic        BUS_RDWR,
  input  logic [7:0]  BUS_DOUT,
  output logic [2:0]  o_dbg_state
);

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES);

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [2:0]  r_settle;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_cin;
  logic [7:0]  r_byte0;
  logic [7:0]  r_byte1;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_sum;
  logic        r_rsp_cout;
  logic        r_rsp_err;
  logic [7:0]  r_bus_din;
  logic [7:0]  r_bus_addr;
  logic        r_bus_rdwr;
  logic [2:0]  w_idx_next;

  assign w_idx_next = r_idx + 3'd1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid and payload stay stable until then. req_ready is a pure
  // function of the state register, never of rsp_ready.
  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_sum     = r_rsp_sum;
  assign rsp_cout    = r_rsp_cout;
  assign rsp_err     = r_rsp_err;
  assign BUS_DIN     = r_bus_din;
  assign BUS_ADDR    = r_bus_addr;
  assign BUS_RDWR    = r_bus_rdwr;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_settle    <= 3'd0;
      r_a         <= 16'd0;
      r_b         <= 16'd0;
      r_cin       <= 1'b0;
      r_byte0     <= 8'd0;
      r_byte1     <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= 16'd0;
      r_rsp_cout  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_bus_din   <= 8'd0;
      r_bus_addr  <= ADDR_IDLE;
      r_bus_rdwr  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_a        <= req_a;
            r_b        <= req_b;
            r_cin      <= req_cin;
            r_idx      <= 3'd0;
            r_state    <= ST_WR;
            r_bus_rdwr <= 1'b1;
            r_bus_addr <= A_LO;
            r_bus_din  <= req_a[7:0];
          end
        end
        ST_WR: begin
          if (r_idx == 3'd4) begin
            r_state    <= ST_SETTLE;
            r_settle   <= 3'd1;
            r_bus_rdwr <= 1'b0;
            r_bus_addr <= ADDR_IDLE;
            r_bus_din  <= 8'd0;
          end else begin
            r_idx      <= w_idx_next;
            r_bus_addr <= {5'd0, w_idx_next};
            r_bus_din  <= wr_byte(r_a, r_b, r_cin, w_idx_next);
          end
        end
        ST_SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state    <= ST_RD;
            r_idx      <= 3'd0;
            r_bus_addr <= SUM_LO;
          end else begin
            r_settle <= r_settle + 3'd1;
          end
        end
        ST_RD: begin
          // Read data lags its address by one cycle, so byte n lands while n+1 is driven
          if (r_idx == 3'd1) r_byte0 <= BUS_DOUT;
          if (r_idx == 3'd2) begin
            r_byte1    <= BUS_DOUT;
            r_state    <= ST_CAP;
            r_bus_addr <= ADDR_IDLE;
          end else begin
            r_idx      <= w_idx_next;
            r_bus_addr <= {5'd0, w_idx_next};
          end
        end
        ST_CAP: begin
          r_rsp_sum   <= {r_byte1, r_byte0};
          r_rsp_cout  <= BUS_DOUT[0];
          r_rsp_err   <= |BUS_DOUT[7:1];
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_bus_rdwr  <= 1'b0;
          r_bus_addr  <= ADDR_IDLE;
          r_bus_din   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca16_host.sv
// Bench for rca16_host: a register-bus adder model plus directed and random
// transactions checked against plain a+b+cin arithmetic.
module tb_rca16_host;

  localparam int         SETTLE  = 1;
  localparam int         LAT     = 9 + SETTLE;
  localparam int         SPACING = 11 + SETTLE;
  localparam logic [7:0] AIDLE   = 8'hFF;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_err;
  logic [7:0]  BUS_DIN;
  logic [7:0]  BUS_ADDR;
  logic        BUS_RDWR;
  logic [7:0]  BUS_DOUT;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [16:0] exp_q[$];
  logic [15:0] wr_q[$];
  bit          force_b2 = 1'b0;
  bit          bad_write = 1'b0;
  logic [7:0]  regs[5];
  logic [16:0] bus_sum;

  rca16_host #(.ADDR_IDLE(AIDLE), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .BUS_DIN(BUS_DIN), .BUS_ADDR(BUS_ADDR), .BUS_RDWR(BUS_RDWR),
    .BUS_DOUT(BUS_DOUT), .o_dbg_state(dbg_state)
  );

  // clock / reset-shared adder wrapper model
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign bus_sum = {1'b0, regs[1], regs[0]} + {1'b0, regs[3], regs[2]} + 17'(regs[4][0]);

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 5; i++) regs[i] <= 8'd0;
      BUS_DOUT <= 8'd0;
    end else begin
      if (BUS_RDWR) begin
        wr_q.push_back({BUS_ADDR, BUS_DIN});
        if (BUS_ADDR <= 8'd4) regs[BUS_ADDR[2:0]] <= BUS_DIN;
        else bad_write <= 1'b1;
      end
      case (BUS_ADDR)
        8'd0:    BUS_DOUT <= bus_sum[7:0];
        8'd1:    BUS_DOUT <= bus_sum[15:8];
        8'd2:    BUS_DOUT <= force_b2 ? 8'h03 : {7'd0, bus_sum[16]};
        default: BUS_DOUT <= 8'd0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request and return at the falling edge just after acceptance.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    req_a = a; req_b = b; req_cin = c; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("accept_in_time", 32'(req_ready === 1'b1), 32'd1);
    exp_q.push_back({1'b0, a} + {1'b0, b} + 17'(c));
    @(negedge CLK);
    acc_cyc = cyc;
    req_a = 16'($urandom); req_b = 16'($urandom); req_cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rsp(input int hold, input bit b2b, input bit b2_forced);
    int lat;
    logic [16:0] e;
    logic exp_cout;
    logic exp_err;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    chk("latency", lat, LAT);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    exp_cout = b2_forced ? 1'b1 : e[16];
    exp_err  = b2_forced;
    if (!b2b) req_valid = 1'b0;
    chk("rsp_sum", rsp_sum, e[15:0]);
    chk("rsp_cout", rsp_cout, exp_cout);
    chk("rsp_err", rsp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_sum", rsp_sum, e[15:0]);
      chk("hold_cout", rsp_cout, exp_cout);
      chk("hold_req_ready", req_ready, 0);
    end
    if (hold > 0) begin
      rsp_ready = 1'b1;
      @(negedge CLK);
      chk("consumed_valid", rsp_valid, 0);
      chk("consumed_req_ready", req_ready, 1);
    end
  endtask

  initial begin
    logic [15:0] exp_tr[5];
    int prev_acc;
    int seen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    RST = 1'b1; req_valid = 1'b0; req_a = 16'd0; req_b = 16'd0; req_cin = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_bus_rdwr", BUS_RDWR, 0);
    chk("rst_bus_addr", BUS_ADDR, AIDLE);
    chk("rst_bus_din", BUS_DIN, 0);
    RST = 1'b0;
    @(negedge CLK);

    // carry out of the top bit
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_rsp(0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);

    // write trace and result
    wr_q.delete();
    send(16'h1234, 16'h4321, 1'b1);
    chk("bus_wr_mid_rdwr", BUS_RDWR, 1);
    wait_rsp(0, 1'b0, 1'b0);
    exp_tr = '{16'h0034, 16'h0112, 16'h0221, 16'h0343, 16'h0401};
    chk("wr_trace_len", wr_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("wr_trace_%0d", i), (wr_q.size() > i) ? wr_q[i] : 16'hxxxx, exp_tr[i]);
    repeat (2) @(negedge CLK);

    // consumer stall
    rsp_ready = 1'b0;
    send(16'hA5A5, 16'h5A5B, 1'b0);
    wait_rsp(5, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);

    // reset in WR cycle 3, then a fresh request
    send(16'h000F, 16'h00F1, 1'b0);
    repeat (3) @(negedge CLK);
    chk("abort_in_wr3", BUS_ADDR, 3);
    RST = 1'b1; req_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_bus_rdwr", BUS_RDWR, 0);
    chk("abort_bus_addr", BUS_ADDR, AIDLE);
    chk("abort_bus_din", BUS_DIN, 0);
    void'(exp_q.pop_front());
    seen = 0;
    repeat (15) begin
      @(negedge CLK);
      if (rsp_valid === 1'b1) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    send(16'h000F, 16'h00F1, 1'b0);
    wait_rsp(0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);

    // wrapper reporting a malformed carry byte
    force_b2 = 1'b1;
    send(16'h0001, 16'h0002, 1'b0);
    wait_rsp(0, 1'b0, 1'b1);
    force_b2 = 1'b0;
    repeat (2) @(negedge CLK);

    // back-to-back random traffic
    prev_acc = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (i % 10 == 0) begin ra = 16'hFFFF; rb = 16'($urandom_range(0, 1)); end
      send(ra, rb, rc);
      if (i > 0) chk("spacing", acc_cyc - prev_acc, SPACING);
      prev_acc = acc_cyc;
      wait_rsp(0, 1'b1, 1'b0);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("no_bad_write", bad_write, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
